// File: rtl/cam_insert_ctrl.sv
// -----------------------------------------------------------------------------
// cam_insert_ctrl
//
// Request sequencer that sits directly upstream of a 2**INDEX_WIDTH-entry CAM.
// It accepts one LOOKUP / INSERT / READ command at a time and drives the CAM
// search, read and write ports. It returns exactly one response per command.
//
// INSERT searches before it writes. A hit returns the index that already
// holds the key, so duplicate keys are never created. A miss allocates a slot
// and writes the key into it. Slots are allocated in fill order first. Once
// every slot has been written, allocation continues round-robin and
// overwrites (evicts) older entries.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   req_valid_i/ready_o   command handshake (transfer when valid && ready)
//   req_op_i              00 LOOKUP, 01 INSERT, 10 READ, 11 treated as LOOKUP
//   req_data_i            key for LOOKUP / INSERT
//   req_index_i           entry index for READ
//   rsp_valid_o/ready_i   response handshake (transfer when valid && ready)
//   rsp_hit_o             LOOKUP/INSERT: key found; READ: entry valid
//   rsp_index_o           matched, allocated or read index
//   rsp_data_o            READ value (0 for other ops)
//   rsp_evict_o           INSERT overwrote a previously written entry
//   cam_write_*           CAM write port (one-cycle strobe)
//   cam_read_*            CAM read request and its combinational result
//   cam_search_*          CAM search request and its combinational result
// -----------------------------------------------------------------------------
module cam_insert_ctrl #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,

  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [1:0]             req_op_i,
  input  logic [DATA_WIDTH-1:0]  req_data_i,
  input  logic [INDEX_WIDTH-1:0] req_index_i,

  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic                   rsp_hit_o,
  output logic [INDEX_WIDTH-1:0] rsp_index_o,
  output logic [DATA_WIDTH-1:0]  rsp_data_o,
  output logic                   rsp_evict_o,

  output logic                   cam_write_o,
  output logic [INDEX_WIDTH-1:0] cam_write_index_o,
  output logic [DATA_WIDTH-1:0]  cam_write_data_o,

  output logic                   cam_read_o,
  output logic [INDEX_WIDTH-1:0] cam_read_index_o,
  input  logic                   cam_read_valid_i,
  input  logic [DATA_WIDTH-1:0]  cam_read_value_i,

  output logic                   cam_search_o,
  output logic [DATA_WIDTH-1:0]  cam_search_data_o,
  input  logic                   cam_search_valid_i,
  input  logic [INDEX_WIDTH-1:0] cam_search_index_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // ready for a command
    ST_ISSUE = 2'd1,  // CAM search or read in flight
    ST_WRITE = 2'd2,  // INSERT miss: write key to alloc_ptr
    ST_RESP  = 2'd3   // response presented until consumed
  } state_e;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_INSERT = 2'b01,
    OP_READ   = 2'b10,
    OP_RSVD   = 2'b11
  } op_e;

  state_e                 state_q,     state_d;
  op_e                    op_q,        op_d;
  logic [DATA_WIDTH-1:0]  key_q,       key_d;
  logic [INDEX_WIDTH-1:0] index_q,     index_d;
  logic                   rsp_hit_q,   rsp_hit_d;
  logic [INDEX_WIDTH-1:0] rsp_index_q, rsp_index_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q,  rsp_data_d;
  logic                   rsp_evict_q, rsp_evict_d;
  logic [INDEX_WIDTH-1:0] alloc_ptr_q, alloc_ptr_d;
  logic                   full_q,      full_d;

  // The reserved opcode falls into the lookup path because only READ and
  // INSERT are decoded explicitly.
  logic is_read;
  logic is_insert;
  assign is_read   = (op_q == OP_READ);
  assign is_insert = (op_q == OP_INSERT);

  logic req_fire;
  logic rsp_fire;
  assign req_fire = (state_q == ST_IDLE) && req_valid_i;
  assign rsp_fire = (state_q == ST_RESP) && rsp_ready_i;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Command, response and allocation registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q        <= OP_LOOKUP;
      key_q       <= '0;
      index_q     <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_index_q <= '0;
      rsp_data_q  <= '0;
      rsp_evict_q <= 1'b0;
      alloc_ptr_q <= '0;
      full_q      <= 1'b0;
    end else begin
      op_q        <= op_d;
      key_q       <= key_d;
      index_q     <= index_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_index_q <= rsp_index_d;
      rsp_data_q  <= rsp_data_d;
      rsp_evict_q <= rsp_evict_d;
      alloc_ptr_q <= alloc_ptr_d;
      full_q      <= full_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_fire) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        // Only an INSERT that misses needs the extra write cycle.
        if (is_insert && !cam_search_valid_i) state_d = ST_WRITE;
        else                                  state_d = ST_RESP;
      end
      ST_WRITE: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    op_d        = op_q;
    key_d       = key_q;
    index_d     = index_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_index_d = rsp_index_q;
    rsp_data_d  = rsp_data_q;
    rsp_evict_d = rsp_evict_q;
    alloc_ptr_d = alloc_ptr_q;
    full_d      = full_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          op_d    = op_e'(req_op_i);
          key_d   = req_data_i;
          index_d = req_index_i;
        end
      end

      ST_ISSUE: begin
        // The CAM answers combinationally in this cycle. Its result is
        // captured here and then held stable for the whole response phase.
        rsp_evict_d = 1'b0;
        if (is_read) begin
          rsp_hit_d   = cam_read_valid_i;
          rsp_index_d = index_q;
          rsp_data_d  = cam_read_valid_i ? cam_read_value_i : '0;
        end else begin
          rsp_hit_d   = cam_search_valid_i;
          rsp_index_d = cam_search_valid_i ? cam_search_index_i : '0;
          rsp_data_d  = '0;
        end
      end

      ST_WRITE: begin
        rsp_hit_d   = 1'b0;
        rsp_index_d = alloc_ptr_q;
        rsp_data_d  = '0;
        // An entry is being overwritten only once the pointer has wrapped.
        rsp_evict_d = full_q;
        alloc_ptr_d = alloc_ptr_q + INDEX_WIDTH'(1);
        if (alloc_ptr_q == '1) full_d = 1'b1;
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // Held low while reset is asserted so that no command is taken before
    // the CAM and this block leave reset together.
    req_ready_o       = reset && (state_q == ST_IDLE);

    rsp_valid_o       = (state_q == ST_RESP);
    rsp_hit_o         = rsp_valid_o && rsp_hit_q;
    rsp_index_o       = rsp_valid_o ? rsp_index_q : '0;
    rsp_data_o        = rsp_valid_o ? rsp_data_q  : '0;
    rsp_evict_o       = rsp_valid_o && rsp_evict_q;

    cam_search_o      = (state_q == ST_ISSUE) && !is_read;
    cam_search_data_o = cam_search_o ? key_q : '0;

    cam_read_o        = (state_q == ST_ISSUE) && is_read;
    cam_read_index_o  = cam_read_o ? index_q : '0;

    cam_write_o       = (state_q == ST_WRITE);
    cam_write_index_o = cam_write_o ? alloc_ptr_q : '0;
    cam_write_data_o  = cam_write_o ? key_q : '0;
  end

endmodule
